scp_mem_sequencer: RTL and testbench
====================================

Name: scp_mem_sequencer

Overview:
- Multi-cycle sequencer for the SCP datapath when instruction fetch and data load/store share one memory port.
- Steps each instruction through FETCH, EXEC, optional MEM and COMMIT.
- Owns the PC and the instruction register; drives the shared port with a req/ack handshake.
- Gates architectural updates (PC write, register-file write) to a single commit cycle; a watchdog halts the core on a hung memory.

Parameters:
- ADDR_WIDTH, 32, memory address and PC width
- DATA_WIDTH, 32, instruction and data word width
- RESET_PC, 0, PC value loaded on reset
- TIMEOUT_CYCLES, 255, maximum wait cycles for memAck before halting (1..65535)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- pcIn  in  ADDR_WIDTH  next-PC from the datapath pcSel mux
- isLoad  in  1  decoded load (opcode 0110), valid in EXEC
- isStore  in  1  decoded store (opcode 0101), valid in EXEC
- aluOut  in  ADDR_WIDTH  effective data address, valid in EXEC
- storeData  in  DATA_WIDTH  store data (rs2 value), valid in EXEC
- memReq  out  1  memory request
- memWrEn  out  1  write qualifier for memReq
- memAddr  out  ADDR_WIDTH  memory address
- memWrData  out  DATA_WIDTH  memory write data
- memAck  in  1  memory completion; read data valid in the same cycle
- memRdData  in  DATA_WIDTH  memory read data
- pc  out  ADDR_WIDTH  current PC register
- instruction  out  DATA_WIDTH  instruction register, to decode
- loadData  out  DATA_WIDTH  registered load result, to the regFileWrSel MEM leg
- pcWrEn  out  1  one-cycle pulse; pc takes pcIn
- regFileWrCommit  out  1  one-cycle pulse qualifying the controller's regFileWrEn
- halted  out  1  core halted (sticky)
- errCode  out  2  00 none, 01 fetch timeout, 10 data timeout, 11 illegal load+store

Behaviour:
- States: IDLE, FETCH, EXEC, MEM, COMMIT, HALT.
- All state and registers update on the rising edge of clk.
- reset low, sampled at an edge:
  - state=IDLE, pc=RESET_PC, instruction=0, loadData=0, address/data latches=0, wait counter=0.
  - halted=0, errCode=00.
  - All outputs decode from state, so memReq=0, memWrEn=0, pcWrEn=0, regFileWrCommit=0.
- IDLE: one cycle, then FETCH. The first memReq is high in the second cycle after reset is released.
- FETCH:
  - memReq=1, memWrEn=0, memAddr=pc.
  - On memAck: instruction takes memRdData, go to EXEC.
  - Ack in the first FETCH cycle is accepted (zero-wait).
- EXEC: exactly one cycle; no memory activity (memReq=0).
  - isLoad=1 and isStore=1: go to HALT, errCode=11.
  - isLoad or isStore: latch aluOut into the address latch, storeData into the write-data latch and isStore into a write flag; go to MEM.
  - Otherwise go to COMMIT.
- MEM:
  - memReq=1, memAddr=address latch, memWrData=write-data latch, memWrEn=write flag.
  - Values are held stable for the whole request.
  - On memAck: if load, loadData takes memRdData; go to COMMIT.
- COMMIT: one cycle; go to FETCH.
  - pcWrEn=1; pc takes pcIn at the end of the cycle.
  - regFileWrCommit=1 unless the instruction was a store.
- memWrData is don't-care, driven 0, outside MEM writes. memAddr=0 outside FETCH/MEM.
- Latency with zero-wait memory:
  - ALU/CMP/BRANCH/JAL: 3 cycles.
  - LOAD/STORE: 4 cycles.
  - Each wait cycle adds 1.
- Watchdog:
  - Counter clears on entering FETCH or MEM and increments each cycle memReq=1 without memAck.
  - No memAck after TIMEOUT_CYCLES wait cycles: go to HALT, errCode=01 (FETCH) or 10 (MEM).
  - memAck in the same cycle the count is reached wins; no error.
- HALT: memReq=0, no pulses, halted=1, errCode held; exited only by reset.
- memAck outside FETCH/MEM is ignored and changes no state.
- Reset mid-transaction (FETCH/MEM): request abandoned, memReq low on the next cycle; an ack arriving in that cycle is ignored.
- PC arithmetic is performed upstream. pc wraps naturally at ADDR_WIDTH; no overflow detection.

Test Plan:
- Reset then ALU instruction, memAck tied high, pcIn=0x4 -> memReq rises cycle 2 with memAddr=0x0; pcWrEn pulses cycle 4; pc=0x4; regFileWrCommit=1; next fetch at 0x4.
- Load with aluOut=0x100, memory returns 0xDEADBEEF after 3 wait cycles -> memAddr=0x100, memWrEn=0 held 4 cycles; loadData=0xDEADBEEF; regFileWrCommit pulses once; 7 cycles total.
- Store, storeData=0x12345678, aluOut=0x200 -> memWrEn=1, memWrData=0x12345678 for the MEM cycle; regFileWrCommit=0; pcWrEn=1.
- TIMEOUT_CYCLES=4, memAck never asserts in FETCH -> HALT after 4 wait cycles; halted=1, errCode=01; memReq=0 thereafter; reset clears.
- isLoad=isStore=1 in EXEC -> HALT, errCode=11; pc unchanged; no pcWrEn.
- reset low during MEM wait with memAck in the following cycle -> state IDLE, no loadData update, pc=RESET_PC.

Source files
------------

// File: rtl/scp_mem_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/COMMIT sequencer for a core whose instruction fetch and
// data accesses share one req/ack memory port; commits PC/regfile writes in one cycle.
module scp_mem_sequencer #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pcIn,
  input  logic                  isLoad,
  input  logic                  isStore,
  input  logic [ADDR_WIDTH-1:0] aluOut,
  input  logic [DATA_WIDTH-1:0] storeData,
  output logic                  memReq,
  output logic                  memWrEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWrData,
  input  logic                  memAck,
  input  logic [DATA_WIDTH-1:0] memRdData,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] loadData,
  output logic                  pcWrEn,
  output logic                  regFileWrCommit,
  output logic                  halted,
  output logic [1:0]            errCode
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_COMMIT, S_HALT
  } state_e;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_FETCH  = 2'b01;
  localparam logic [1:0] ERR_DATA   = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  // Index of the last permitted wait cycle; no ack here means timeout.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] load_q, load_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic [15:0]           wait_q, wait_d;
  logic [1:0]            err_q, err_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      load_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      wait_q  <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      load_q  <= load_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    load_d          = load_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wr_d            = wr_q;
    wait_d          = wait_q;
    err_d           = err_q;
    memReq          = 1'b0;
    memWrEn         = 1'b0;
    memAddr         = '0;
    memWrData       = '0;
    pcWrEn          = 1'b0;
    regFileWrCommit = 1'b0;
    halted          = 1'b0;

    case (state_q)
      S_IDLE: begin
        wait_d  = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        memReq  = 1'b1;
        memAddr = pc_q;
        // An ack always beats the watchdog, even on the last allowed cycle.
        if (memAck) begin
          instr_d = memRdData;
          state_d = S_EXEC;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = ERR_FETCH;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_EXEC: begin
        if (isLoad && isStore) begin
          err_d   = ERR_ILLEGAL;
          state_d = S_HALT;
        end else if (isLoad || isStore) begin
          addr_d  = aluOut;
          wdata_d = storeData;
          wr_d    = isStore;
          wait_d  = '0;
          state_d = S_MEM;
        end else begin
          wr_d    = 1'b0;
          state_d = S_COMMIT;
        end
      end
      S_MEM: begin
        memReq    = 1'b1;
        memAddr   = addr_q;
        memWrEn   = wr_q;
        memWrData = wr_q ? wdata_q : '0;
        if (memAck) begin
          if (!wr_q) load_d = memRdData;
          state_d = S_COMMIT;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = ERR_DATA;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_COMMIT: begin
        pcWrEn          = 1'b1;
        regFileWrCommit = !wr_q;
        pc_d            = pcIn;
        wait_d          = '0;
        state_d         = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pc          = pc_q;
  assign instruction = instr_q;
  assign loadData    = load_q;
  assign errCode     = err_q;

endmodule

// File: tb/tb_scp_mem_sequencer.sv
// Directed bench for scp_mem_sequencer: a per-cycle vector table for the main
// instruction flow, plus hand sequences for reset-in-MEM and both watchdog timeouts.
module tb_scp_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcIn, aluOut, storeData, memRdData;
  logic        isLoad, isStore, memAck;
  logic        memReq, memWrEn, pcWrEn, regFileWrCommit, halted;
  logic [31:0] memAddr, memWrData, pc, instruction, loadData;
  logic [1:0]  errCode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scp_mem_sequencer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .pcIn(pcIn), .isLoad(isLoad), .isStore(isStore),
    .aluOut(aluOut), .storeData(storeData), .memReq(memReq), .memWrEn(memWrEn),
    .memAddr(memAddr), .memWrData(memWrData), .memAck(memAck), .memRdData(memRdData),
    .pc(pc), .instruction(instruction), .loadData(loadData), .pcWrEn(pcWrEn),
    .regFileWrCommit(regFileWrCommit), .halted(halted), .errCode(errCode)
  );

  typedef struct {
    logic        ack;
    logic [31:0] rd;
    logic        ld, st;
    logic [31:0] alu, sd, pcin;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wd;
    logic        e_pcwe, e_cmt, e_halt;
    logic [1:0]  e_err;
    logic [31:0] e_pc, e_instr, e_ld;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ack, input logic [31:0] rd, input logic ld, input logic st,
                     input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pcin,
                     input logic e_req, input logic e_we, input logic [31:0] e_addr,
                     input logic [31:0] e_wd, input logic e_pcwe, input logic e_cmt,
                     input logic e_halt, input logic [1:0] e_err, input logic [31:0] e_pc,
                     input logic [31:0] e_instr, input logic [31:0] e_ld);
    vec_t v;
    v.ack = ack; v.rd = rd; v.ld = ld; v.st = st; v.alu = alu; v.sd = sd; v.pcin = pcin;
    v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd; v.e_pcwe = e_pcwe;
    v.e_cmt = e_cmt; v.e_halt = e_halt; v.e_err = e_err; v.e_pc = e_pc;
    v.e_instr = e_instr; v.e_ld = e_ld;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ack, input logic [31:0] rd,
                       input logic ld, input logic st, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [31:0] pcin);
    reset = rst; memAck = ack; memRdData = rd; isLoad = ld; isStore = st;
    aluOut = alu; storeData = sd; pcIn = pcin;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ALU, zero-wait; load with 3 waits; store; fetch ack on the last allowed wait; illegal ld+st.
    //   ack rd            ld st alu     sd            pcin    req we addr    wd            pw cm h  err pc     instr  ld
    add(1, 32'hA1,       0, 0, 32'h0,   32'h0,        32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0, 32'h0,  32'h0);
    add(1, 32'hA1,       0, 0, 32'h0,   32'h0,        32'h0,  1, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0, 32'h0,  32'h0);
    add(0, 32'h0,        0, 0, 32'h0,   32'h0,        32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0, 32'hA1, 32'h0);
    add(0, 32'h0,        0, 0, 32'h0,   32'h0,        32'h4,  0, 0, 32'h0,   32'h0,        1, 1, 0, 0, 32'h0, 32'hA1, 32'h0);
    add(1, 32'hB2,       0, 0, 32'h0,   32'h0,        32'h0,  1, 0, 32'h4,   32'h0,        0, 0, 0, 0, 32'h4, 32'hA1, 32'h0);
    add(0, 32'h0,        1, 0, 32'h100, 32'h0,        32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h4, 32'hB2, 32'h0);
    add(0, 32'h0,        0, 0, 32'h0,   32'h0,        32'h0,  1, 0, 32'h100, 32'h0,        0, 0, 0, 0, 32'h4, 32'hB2, 32'h0);
    add(0, 32'h0,        0, 0, 32'h0,   32'h0,        32'h0,  1, 0, 32'h100, 32'h0,        0, 0, 0, 0, 32'h4, 32'hB2, 32'h0);
    add(0, 32'h0,        0, 0, 32'h0,   32'h0,        32'h0,  1, 0, 32'h100, 32'h0,        0, 0, 0, 0, 32'h4, 32'hB2, 32'h0);
    add(1, 32'hDEADBEEF, 0, 0, 32'h0,   32'h0,        32'h0,  1, 0, 32'h100, 32'h0,        0, 0, 0, 0, 32'h4, 32'hB2, 32'h0);
    add(0, 32'h0,        0, 0, 32'h0,   32'h0,        32'h8,  0, 0, 32'h0,   32'h0,        1, 1, 0, 0, 32'h4, 32'hB2, 32'hDEADBEEF);
    add(1, 32'hC3,       0, 0, 32'h0,   32'h0,        32'h0,  1, 0, 32'h8,   32'h0,        0, 0, 0, 0, 32'h8, 32'hB2, 32'hDEADBEEF);
    add(1, 32'h77,       0, 1, 32'h200, 32'h12345678, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h8, 32'hC3, 32'hDEADBEEF);
    add(1, 32'h99,       0, 0, 32'h0,   32'h0,        32'h0,  1, 1, 32'h200, 32'h12345678, 0, 0, 0, 0, 32'h8, 32'hC3, 32'hDEADBEEF);
    add(1, 32'h88,       0, 0, 32'h0,   32'h0,        32'hC,  0, 0, 32'h0,   32'h0,        1, 0, 0, 0, 32'h8, 32'hC3, 32'hDEADBEEF);
    add(0, 32'h0,        0, 0, 32'h0,   32'h0,        32'h0,  1, 0, 32'hC,   32'h0,        0, 0, 0, 0, 32'hC, 32'hC3, 32'hDEADBEEF);
    add(0, 32'h0,        0, 0, 32'h0,   32'h0,        32'h0,  1, 0, 32'hC,   32'h0,        0, 0, 0, 0, 32'hC, 32'hC3, 32'hDEADBEEF);
    add(0, 32'h0,        0, 0, 32'h0,   32'h0,        32'h0,  1, 0, 32'hC,   32'h0,        0, 0, 0, 0, 32'hC, 32'hC3, 32'hDEADBEEF);
    add(1, 32'hD4,       0, 0, 32'h0,   32'h0,        32'h0,  1, 0, 32'hC,   32'h0,        0, 0, 0, 0, 32'hC, 32'hC3, 32'hDEADBEEF);
    add(0, 32'h0,        1, 1, 32'h500, 32'h0,        32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'hC, 32'hD4, 32'hDEADBEEF);
    add(1, 32'h11,       0, 0, 32'h0,   32'h0,        32'h40, 0, 0, 32'h0,   32'h0,        0, 0, 1, 3, 32'hC, 32'hD4, 32'hDEADBEEF);
    add(1, 32'h22,       1, 0, 32'h0,   32'h0,        32'h40, 0, 0, 32'h0,   32'h0,        0, 0, 1, 3, 32'hC, 32'hD4, 32'hDEADBEEF);

    drive(0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
    tick(); tick();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(1, vecs[i].ack, vecs[i].rd, vecs[i].ld, vecs[i].st, vecs[i].alu, vecs[i].sd, vecs[i].pcin);
      chk($sformatf("v%0d memReq", i), 32'(memReq), 32'(vecs[i].e_req));
      chk($sformatf("v%0d memWrEn", i), 32'(memWrEn), 32'(vecs[i].e_we));
      chk($sformatf("v%0d memAddr", i), memAddr, vecs[i].e_addr);
      chk($sformatf("v%0d memWrData", i), memWrData, vecs[i].e_wd);
      chk($sformatf("v%0d pcWrEn", i), 32'(pcWrEn), 32'(vecs[i].e_pcwe));
      chk($sformatf("v%0d regFileWrCommit", i), 32'(regFileWrCommit), 32'(vecs[i].e_cmt));
      chk($sformatf("v%0d halted", i), 32'(halted), 32'(vecs[i].e_halt));
      chk($sformatf("v%0d errCode", i), 32'(errCode), 32'(vecs[i].e_err));
      chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d instruction", i), instruction, vecs[i].e_instr);
      chk($sformatf("v%0d loadData", i), loadData, vecs[i].e_ld);
      $display("vec %0d: req=%0b we=%0b addr=%08h pc=%08h instr=%08h ld=%08h err=%0d",
               i, memReq, memWrEn, memAddr, pc, instruction, loadData, errCode);
      tick();
    end

    // Reset while a load is waiting in MEM; the ack in the following cycle must be ignored.
    drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("rst halted", 32'(halted), 32'h0);
    chk("rst errCode", 32'(errCode), 32'h0);
    drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(1, 1, 32'hE5, 0, 0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(1, 0, 32'h0, 1, 0, 32'h300, 32'h0, 32'h0);
    tick();
    drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
    chk("midmem memReq", 32'(memReq), 32'h1);
    chk("midmem memAddr", memAddr, 32'h300);
    drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(1, 1, 32'h55, 0, 0, 32'h0, 32'h0, 32'h0);
    chk("postrst memReq", 32'(memReq), 32'h0);
    chk("postrst pc", pc, 32'h0);
    chk("postrst instruction", instruction, 32'h0);
    tick();
    chk("postrst loadData", loadData, 32'h0);
    chk("postrst fetch memReq", 32'(memReq), 32'h1);
    chk("postrst fetch memAddr", memAddr, 32'h0);
    $display("seq reset-in-MEM: req=%0b pc=%08h ld=%08h", memReq, pc, loadData);

    // Data watchdog: fetch acked, then load never acked for 4 wait cycles.
    drive(1, 1, 32'hF6, 0, 0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(1, 0, 32'h0, 1, 0, 32'h400, 32'h0, 32'h0);
    tick();
    drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dto wait%0d memReq", k), 32'(memReq), 32'h1);
      chk($sformatf("dto wait%0d halted", k), 32'(halted), 32'h0);
      tick();
    end
    chk("dto halted", 32'(halted), 32'h1);
    chk("dto errCode", 32'(errCode), 32'h2);
    chk("dto memReq", 32'(memReq), 32'h0);
    $display("seq data timeout: halted=%0b err=%0d", halted, errCode);

    // Fetch watchdog, then a late ack in HALT, then reset clears the sticky halt.
    drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fto wait%0d memReq", k), 32'(memReq), 32'h1);
      tick();
    end
    chk("fto halted", 32'(halted), 32'h1);
    chk("fto errCode", 32'(errCode), 32'h1);
    chk("fto memReq", 32'(memReq), 32'h0);
    drive(1, 1, 32'h66, 0, 0, 32'h0, 32'h0, 32'h80);
    tick();
    chk("fto late-ack halted", 32'(halted), 32'h1);
    chk("fto late-ack memReq", 32'(memReq), 32'h0);
    chk("fto late-ack pcWrEn", 32'(pcWrEn), 32'h0);
    chk("fto late-ack instruction", instruction, 32'h0);
    drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("fto clr halted", 32'(halted), 32'h0);
    chk("fto clr errCode", 32'(errCode), 32'h0);
    $display("seq fetch timeout: cleared halted=%0b err=%0d", halted, errCode);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
